hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline hold/branch-notify logic, for a configurable register count and pipeline depth.
- Tracks in-flight writers of W, carry and the Ri/POi register file in a registered tag pipeline with per-resource pending counters.
- Stalls issue on read-after-write hazards, notifies the branch block when a branch tag reaches a configurable stage, and supports pipeline flush.
- Sits between decode (stage 2) and the execute/writeback stages.

Parameters:
- NREG, 32, number of tracked registers Ri/POi.
- RADDR_W, 5, register address width; NREG <= 2**RADDR_W.
- DEPTH, 3, stages from issue to writeback; range 1..7.
- BR_STAGE, 2, stage index (1..DEPTH) at which branch_update fires.
- HOLD_MAX, 15, watchdog limit in cycles; used only with HOLD_WATCHDOG_EN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- issue_valid  in  1  a micro-instruction is presented at decode
- issue_rd_w  in  1  instruction reads W
- issue_wr_w  in  1  instruction writes W
- issue_rd_r  in  1  instruction reads register issue_ra
- issue_wr_r  in  1  instruction writes register issue_rc
- issue_rd_c  in  1  instruction reads carry
- issue_wr_c  in  1  instruction writes carry
- issue_branch  in  1  instruction is a branch
- issue_ra  in  RADDR_W  source register
- issue_rc  in  RADDR_W  destination register
- flush  in  1  discard all in-flight tags
- hold  out  1  stall decode this cycle
- issue_accept  out  1  instruction enters the pipeline at this edge
- branch_update  out  1  branch tag is at BR_STAGE
- pending_any  out  1  any counter nonzero
- hold_timeout  out  1  sticky watchdog flag

Behaviour:
- Clock and reset: single clock, clk. reset is synchronous and active-high.
- Reset values: all tags invalid, all counters 0, hold_timeout=0, watchdog count 0. Consequently hold=0, branch_update=0, pending_any=0.
- Tag pipeline:
  - DEPTH registered stages, each holding {valid, wr_w, wr_r, rc, wr_c, branch}.
  - An instruction accepted at edge k occupies stage s during cycle k+s.
  - It retires at the edge ending cycle k+DEPTH.
  - When not accepted, a bubble (valid=0) enters stage 1.
- Counters:
  - w_cnt, c_cnt and r_cnt[NREG], each ceil(log2(DEPTH+1)) bits.
  - Increment on acceptance for each written resource; decrement on retirement of a valid tag writing it.
  - Increment and decrement in the same cycle: net unchanged.
  - Counters cannot exceed DEPTH, so no saturation logic is needed.
- Hazard rule (combinational from registered counters):
  - hold = issue_valid & ~flush & ((issue_rd_w & w_cnt!=0) | (issue_rd_c & c_cnt!=0) | (issue_rd_r & r_cnt[issue_ra]!=0)).
  - No bypass: a writer retiring in the current cycle still causes hold.
  - issue_ra >= NREG never holds.
  - issue_rc >= NREG is not tracked.
- issue_accept = issue_valid & ~hold & ~flush.
- An instruction that reads and writes the same resource is checked only against older writers.
- branch_update = stage[BR_STAGE].valid & stage[BR_STAGE].branch (combinational from registers).
- flush: at the next edge all tags become invalid and all counters clear.
  - A concurrent issue is not accepted; hold=0 while flush=1.
  - Watchdog count clears; hold_timeout is not cleared.
- pending_any = OR of all counters being nonzero.
- reset mid-operation behaves like flush and additionally clears hold_timeout.

Optional Feature:
- Macro: HOLD_WATCHDOG_EN.
- Defined:
  - A counter of consecutive cycles with hold=1 is maintained; it resets to 0 on any cycle with hold=0.
  - When the counter reaches HOLD_MAX, hold_timeout sets and stays set until reset.
- Undefined: no watchdog logic; hold_timeout is tied to 0.

Test Plan:
- Reset: assert reset 2 cycles with issue_valid=1 and issue_rd_r=1 -> hold=0, branch_update=0, pending_any=0, hold_timeout=0 after release.
- RAW on register, DEPTH=3:
  - Cycle 0: issue wr_r rc=5 -> accepted.
  - Cycle 1: issue rd_r ra=5 -> hold=1 in cycles 1, 2, 3; issue_accept=1 in cycle 4.
  - Repeat with ra=6 -> accepted in cycle 1, no hold.
- W and carry: cycle 0 issue wr_c=1 -> cycle 1 issue rd_c=1 held 3 cycles; same sequence with wr_w/rd_w -> identical result.
- Branch, BR_STAGE=2: issue_branch accepted in cycle 0 -> branch_update=1 in cycle 2 only. A held branch produces no pulse until accepted.
- Flush:
  - Accept wr_r rc=9 in cycle 0; flush=1 in cycle 1 -> from cycle 2, pending_any=0.
  - rd_r ra=9 in cycle 2 accepted with no hold.
  - issue_valid=1 concurrent with flush -> issue_accept=0.
- Watchdog (HOLD_WATCHDOG_EN, HOLD_MAX=4, DEPTH=7): force hold for 6 consecutive cycles -> hold_timeout rises after the 4th hold cycle and stays 1 after hold drops; with the macro undefined it stays 0.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Issue-side bus between decode and the hazard scoreboard.
// The decode side drives the micro-instruction fields and flush. The scoreboard answers with hold and issue_accept.
interface hazard_scoreboard_if #(
  parameter int RADDR_W = 5
);
  logic               issue_valid;
  logic               issue_rd_w;
  logic               issue_wr_w;
  logic               issue_rd_r;
  logic               issue_wr_r;
  logic               issue_rd_c;
  logic               issue_wr_c;
  logic               issue_branch;
  logic [RADDR_W-1:0] issue_ra;
  logic [RADDR_W-1:0] issue_rc;
  logic               flush;
  logic               hold;
  logic               issue_accept;

  modport master (
    output issue_valid, issue_rd_w, issue_wr_w, issue_rd_r, issue_wr_r,
           issue_rd_c, issue_wr_c, issue_branch, issue_ra, issue_rc, flush,
    input  hold, issue_accept
  );

  modport slave (
    input  issue_valid, issue_rd_w, issue_wr_w, issue_rd_r, issue_wr_r,
           issue_rd_c, issue_wr_c, issue_branch, issue_ra, issue_rc, flush,
    output hold, issue_accept
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: a tag pipeline plus per-resource pending counters for W, carry and Ri/POi.
// The optional hold watchdog is enabled by defining HOLD_WATCHDOG_EN.
module hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int RADDR_W  = 5,
  parameter int DEPTH    = 3,
  parameter int BR_STAGE = 2,
  parameter int HOLD_MAX = 15
) (
  input  logic                clk,
  input  logic                reset,
  hazard_scoreboard_if.slave  bus,
  output logic                branch_update,
  output logic                pending_any,
  output logic                hold_timeout
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic               valid;
    logic               wr_w;
    logic               wr_r;
    logic [RADDR_W-1:0] rc;
    logic               wr_c;
    logic               branch;
  } tag_t;

  tag_t stage_q [1:DEPTH];
  cnt_t w_cnt;
  cnt_t c_cnt;
  cnt_t r_cnt [NREG];

  tag_t new_tag;
  logic r_busy;
  logic hold;
  logic accept;
  logic rc_tracked;

  function automatic cnt_t next_cnt(input cnt_t cnt, input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   return cnt + 1'b1;
      2'b01:   return cnt - 1'b1;
      default: return cnt;
    endcase
  endfunction

  // Hazard check uses registered counters only, so a writer retiring this cycle still holds.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    r_busy     = 1'b0;
    rc_tracked = 32'(bus.issue_rc) < NREG;
    for (int i = 0; i < NREG; i++) begin
      if (bus.issue_ra == RADDR_W'(i) && r_cnt[i] != '0) r_busy = 1'b1;
    end
    hold = bus.issue_valid & ~bus.flush &
           ((bus.issue_rd_w & (w_cnt != '0)) |
            (bus.issue_rd_c & (c_cnt != '0)) |
            (bus.issue_rd_r & r_busy));
    accept = bus.issue_valid & ~hold & ~bus.flush;

    new_tag = '0;
    if (accept) begin
      new_tag.valid  = 1'b1;
      new_tag.wr_w   = bus.issue_wr_w;
      new_tag.wr_r   = bus.issue_wr_r & rc_tracked;
      new_tag.rc     = bus.issue_rc;
      new_tag.wr_c   = bus.issue_wr_c;
      new_tag.branch = bus.issue_branch;
    end
  end

  assign bus.hold         = hold;
  assign bus.issue_accept = accept;

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      for (int s = 1; s <= DEPTH; s++) stage_q[s] <= '0;
      w_cnt <= '0;
      c_cnt <= '0;
      // NOTE: the counter array is real state that must read zero after reset/flush, so it is cleared explicitly.
      for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage shift on the old values of its neighbour.
      stage_q[1] <= new_tag;
      for (int s = 2; s <= DEPTH; s++) stage_q[s] <= stage_q[s-1];
      w_cnt <= next_cnt(w_cnt, new_tag.wr_w, stage_q[DEPTH].valid & stage_q[DEPTH].wr_w);
      c_cnt <= next_cnt(c_cnt, new_tag.wr_c, stage_q[DEPTH].valid & stage_q[DEPTH].wr_c);
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i] <= next_cnt(r_cnt[i],
                             new_tag.wr_r & (new_tag.rc == RADDR_W'(i)),
                             stage_q[DEPTH].valid & stage_q[DEPTH].wr_r &
                             (stage_q[DEPTH].rc == RADDR_W'(i)));
      end
    end
  end

  assign branch_update = stage_q[BR_STAGE].valid & stage_q[BR_STAGE].branch;

  always_comb begin
    pending_any = (w_cnt != '0) || (c_cnt != '0);
    for (int i = 0; i < NREG; i++) begin
      if (r_cnt[i] != '0) pending_any = 1'b1;
    end
  end

`ifdef HOLD_WATCHDOG_EN
  localparam int WD_W = $clog2(HOLD_MAX + 1);

  logic [WD_W-1:0] hold_cnt;

  // Flush forces hold low, so it also clears the run length. Only reset clears the sticky flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt     <= '0;
      hold_timeout <= 1'b0;
    end else begin
      if (!hold) hold_cnt <= '0;
      else if (hold_cnt != WD_W'(HOLD_MAX)) hold_cnt <= hold_cnt + 1'b1;
      if (hold && hold_cnt == WD_W'(HOLD_MAX - 1)) hold_timeout <= 1'b1;
    end
  end
`else
  assign hold_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: dut_a (DEPTH=3) covers hazards, branch and flush.
// dut_b (DEPTH=7, HOLD_MAX=4) covers the hold watchdog.
module tb_hazard_scoreboard;

  localparam int RADDR_W = 5;

`ifdef HOLD_WATCHDOG_EN
  localparam logic WD = 1'b1;
`else
  localparam logic WD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.RADDR_W(RADDR_W)) bus_a ();
  hazard_scoreboard_if #(.RADDR_W(RADDR_W)) bus_b ();

  logic bu_a, pa_a, to_a;
  logic bu_b, pa_b, to_b;

  hazard_scoreboard #(.NREG(32), .RADDR_W(RADDR_W), .DEPTH(3), .BR_STAGE(2), .HOLD_MAX(15)) dut_a (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus_a),
    .branch_update (bu_a),
    .pending_any   (pa_a),
    .hold_timeout  (to_a)
  );

  hazard_scoreboard #(.NREG(32), .RADDR_W(RADDR_W), .DEPTH(7), .BR_STAGE(2), .HOLD_MAX(4)) dut_b (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus_b),
    .branch_update (bu_b),
    .pending_any   (pa_b),
    .hold_timeout  (to_b)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.issue_valid = 0; bus_a.issue_rd_w = 0; bus_a.issue_wr_w = 0;
    bus_a.issue_rd_r  = 0; bus_a.issue_wr_r = 0; bus_a.issue_rd_c = 0;
    bus_a.issue_wr_c  = 0; bus_a.issue_branch = 0;
    bus_a.issue_ra = '0; bus_a.issue_rc = '0; bus_a.flush = 0;
  endtask

  task automatic idle_b();
    bus_b.issue_valid = 0; bus_b.issue_rd_w = 0; bus_b.issue_wr_w = 0;
    bus_b.issue_rd_r  = 0; bus_b.issue_wr_r = 0; bus_b.issue_rd_c = 0;
    bus_b.issue_wr_c  = 0; bus_b.issue_branch = 0;
    bus_b.issue_ra = '0; bus_b.issue_rc = '0; bus_b.flush = 0;
  endtask

  task automatic drain(input int n);
    idle_a();
    idle_b();
    for (int i = 0; i < n; i++) adv();
  endtask

  // Writer in cycle 0, dependent reader from cycle 1: held cycles 1..3, accepted in cycle 4.
  task automatic raw_seq(input int kind, input string tag);
    idle_a();
    bus_a.issue_valid = 1;
    case (kind)
      0:       begin bus_a.issue_wr_r = 1; bus_a.issue_rc = 5'd5; end
      1:       bus_a.issue_wr_c = 1;
      default: bus_a.issue_wr_w = 1;
    endcase
    settle();
    check({tag, "_wr_acc"}, bus_a.issue_accept, 1'b1);
    adv();
    idle_a();
    bus_a.issue_valid = 1;
    case (kind)
      0:       begin bus_a.issue_rd_r = 1; bus_a.issue_ra = 5'd5; end
      1:       bus_a.issue_rd_c = 1;
      default: bus_a.issue_rd_w = 1;
    endcase
    for (int c = 1; c <= 3; c++) begin
      settle();
      check($sformatf("%s_hold_c%0d", tag, c), bus_a.hold, 1'b1);
      check($sformatf("%s_noacc_c%0d", tag, c), bus_a.issue_accept, 1'b0);
      adv();
    end
    settle();
    check({tag, "_hold_c4"}, bus_a.hold, 1'b0);
    check({tag, "_acc_c4"}, bus_a.issue_accept, 1'b1);
    adv();
    idle_a();
    settle();
    check({tag, "_drained"}, pa_a, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within its time budget");
    $fatal(1, "time budget exceeded");
  end

  initial begin
    idle_a();
    idle_b();

    // Reset with a reading instruction presented.
    reset = 1;
    bus_a.issue_valid = 1; bus_a.issue_rd_r = 1; bus_a.issue_ra = 5'd0;
    adv();
    adv();
    reset = 0;
    settle();
    check("rst_hold", bus_a.hold, 1'b0);
    check("rst_branch", bu_a, 1'b0);
    check("rst_pending", pa_a, 1'b0);
    check("rst_timeout", to_a, 1'b0);
    check("rst_timeout_b", to_b, 1'b0);
    adv();
    drain(4);

    raw_seq(0, "raw_reg");
    drain(2);

    // Different register: no hazard.
    bus_a.issue_valid = 1; bus_a.issue_wr_r = 1; bus_a.issue_rc = 5'd5;
    settle();
    check("nohaz_wr_acc", bus_a.issue_accept, 1'b1);
    adv();
    idle_a();
    bus_a.issue_valid = 1; bus_a.issue_rd_r = 1; bus_a.issue_ra = 5'd6;
    settle();
    check("nohaz_hold", bus_a.hold, 1'b0);
    check("nohaz_acc", bus_a.issue_accept, 1'b1);
    check("nohaz_pending", pa_a, 1'b1);
    adv();
    drain(4);

    raw_seq(1, "raw_carry");
    drain(2);
    raw_seq(2, "raw_w");
    drain(2);

    // Two writers of r3 back to back: reader held until the younger one retires.
    bus_a.issue_valid = 1; bus_a.issue_wr_r = 1; bus_a.issue_rc = 5'd3;
    adv();
    settle();
    check("dbl_wr2_acc", bus_a.issue_accept, 1'b1);
    adv();
    idle_a();
    bus_a.issue_valid = 1; bus_a.issue_rd_r = 1; bus_a.issue_ra = 5'd3;
    for (int c = 2; c <= 4; c++) begin
      settle();
      check($sformatf("dbl_hold_c%0d", c), bus_a.hold, 1'b1);
      adv();
    end
    settle();
    check("dbl_acc_c5", bus_a.issue_accept, 1'b1);
    adv();
    drain(4);

    // Read-and-write of r7 with no older writer is not self-blocked.
    bus_a.issue_valid = 1; bus_a.issue_rd_r = 1; bus_a.issue_ra = 5'd7;
    bus_a.issue_wr_r = 1; bus_a.issue_rc = 5'd7;
    settle();
    check("self_hold", bus_a.hold, 1'b0);
    check("self_acc", bus_a.issue_accept, 1'b1);
    adv();
    bus_a.issue_wr_r = 0;
    settle();
    check("self_then_hold", bus_a.hold, 1'b1);
    adv();
    drain(4);

    // Branch accepted in cycle 0: pulse in cycle 2 only.
    bus_a.issue_valid = 1; bus_a.issue_branch = 1;
    settle();
    check("br_acc", bus_a.issue_accept, 1'b1);
    check("br_c0", bu_a, 1'b0);
    adv();
    idle_a();
    settle(); check("br_c1", bu_a, 1'b0); adv();
    settle(); check("br_c2", bu_a, 1'b1); adv();
    settle(); check("br_c3", bu_a, 1'b0); adv();
    drain(2);

    // Held branch: pulse only two cycles after its eventual acceptance (cycle 4 -> 6).
    bus_a.issue_valid = 1; bus_a.issue_wr_c = 1;
    adv();
    idle_a();
    bus_a.issue_valid = 1; bus_a.issue_rd_c = 1; bus_a.issue_branch = 1;
    for (int c = 1; c <= 3; c++) begin
      settle();
      check($sformatf("hbr_hold_c%0d", c), bus_a.hold, 1'b1);
      check($sformatf("hbr_bu_c%0d", c), bu_a, 1'b0);
      adv();
    end
    settle();
    check("hbr_acc_c4", bus_a.issue_accept, 1'b1);
    adv();
    idle_a();
    settle(); check("hbr_bu_c5", bu_a, 1'b0); adv();
    settle(); check("hbr_bu_c6", bu_a, 1'b1); adv();
    settle(); check("hbr_bu_c7", bu_a, 1'b0); adv();
    drain(2);

    // Flush discards an in-flight r9 writer; concurrent issue is refused.
    bus_a.issue_valid = 1; bus_a.issue_wr_r = 1; bus_a.issue_rc = 5'd9;
    adv();
    idle_a();
    bus_a.flush = 1; bus_a.issue_valid = 1; bus_a.issue_rd_r = 1; bus_a.issue_ra = 5'd9;
    settle();
    check("fl_hold", bus_a.hold, 1'b0);
    check("fl_acc", bus_a.issue_accept, 1'b0);
    check("fl_pend_before", pa_a, 1'b1);
    adv();
    bus_a.flush = 0;
    settle();
    check("fl_pend_after", pa_a, 1'b0);
    check("fl_rd_hold", bus_a.hold, 1'b0);
    check("fl_rd_acc", bus_a.issue_accept, 1'b1);
    adv();
    drain(3);

    // Flush kills a branch before it reaches stage 2.
    bus_a.issue_valid = 1; bus_a.issue_branch = 1;
    adv();
    idle_a();
    bus_a.flush = 1;
    adv();
    bus_a.flush = 0;
    settle();
    check("flbr_bu", bu_a, 1'b0);
    adv();
    drain(3);

    // Watchdog on dut_b: W writer, then 6 held reads of W.
    bus_b.issue_valid = 1; bus_b.issue_wr_w = 1;
    settle();
    check("wd_wr_acc", bus_b.issue_accept, 1'b1);
    adv();
    idle_b();
    bus_b.issue_valid = 1; bus_b.issue_rd_w = 1;
    for (int c = 1; c <= 6; c++) begin
      settle();
      check($sformatf("wd_hold_c%0d", c), bus_b.hold, 1'b1);
      check($sformatf("wd_to_c%0d", c), to_b, (c >= 5) ? WD : 1'b0);
      adv();
    end
    idle_b();
    settle();
    check("wd_hold_drop", bus_b.hold, 1'b0);
    check("wd_to_sticky", to_b, WD);
    check("wd_to_a", to_a, 1'b0);
    adv();
    drain(8);

    // Mid-operation reset: clears the in-flight writer and the sticky watchdog flag.
    bus_a.issue_valid = 1; bus_a.issue_wr_r = 1; bus_a.issue_rc = 5'd4;
    adv();
    idle_a();
    reset = 1;
    adv();
    reset = 0;
    bus_a.issue_valid = 1; bus_a.issue_rd_r = 1; bus_a.issue_ra = 5'd4;
    settle();
    check("mrst_hold", bus_a.hold, 1'b0);
    check("mrst_acc", bus_a.issue_accept, 1'b1);
    check("mrst_pending", pa_a, 1'b0);
    check("mrst_to_b", to_b, 1'b0);
    adv();
    drain(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
